// File: rtl/gate_seq_if.sv
// gate_seq_if: start/result handshake and gate-under-test pins of the sequencer
interface gate_seq_if;
    logic       start;
    logic       gate_y;
    logic       gate_a;
    logic       gate_b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic [3:0] fail_vec;
    modport master (output start, gate_y, input gate_a, gate_b, busy, done, pass, err_count, fail_vec);
    modport slave  (input start, gate_y, output gate_a, gate_b, busy, done, pass, err_count, fail_vec);
endinterface

// File: rtl/gate_seq_checker.sv
// gate_seq_checker: steps a 2-input gate through 00,01,10,11 and checks it against a truth table
module gate_seq_checker #(
    parameter int         DWELL  = 100,
    parameter logic [3:0] EXPECT = 4'b1110
) (
    input  logic      clk,
    input  logic      rst,
    gate_seq_if.slave s
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [15:0] LAST = 16'(DWELL - 1);
    state_t      state, state_n;
    logic [1:0]  vec, vec_n, ab, ab_n;
    logic [15:0] cnt, cnt_n;
    logic [3:0]  fv, fv_n;
    logic [2:0]  ec, ec_n;
    logic        hit, miss;
    assign hit         = cnt == LAST;
    assign miss        = s.gate_y != EXPECT[vec];
    assign s.gate_a    = ab[1];
    assign s.gate_b    = ab[0];
    assign s.busy      = state == RUN;
    assign s.done      = state == DONE;
    assign s.pass      = s.done && fv == 4'd0;
    assign s.err_count = ec;
    assign s.fail_vec  = fv;
    // next state: start launches/relaunches a run, RUN samples and advances at end of each dwell
    always_comb begin
        state_n = state;
        vec_n   = vec;
        cnt_n   = cnt;
        fv_n    = fv;
        ec_n    = ec;
        ab_n    = 2'b00;
        case (state)
            RUN: begin
                ab_n  = vec;
                cnt_n = cnt + 16'd1;
                if (hit) begin
                    if (miss) begin
                        fv_n[vec] = 1'b1;
                        ec_n      = ec + 3'd1;
                    end
                    if (vec == 2'd3) begin
                        state_n = DONE;
                        ab_n    = 2'b00;
                    end else begin
                        vec_n = vec + 2'd1;
                        cnt_n = 16'd0;
                        ab_n  = vec + 2'd1;
                    end
                end
            end
            default: if (s.start) begin
                state_n = RUN;
                vec_n   = 2'd0;
                cnt_n   = 16'd0;
                fv_n    = 4'd0;
                ec_n    = 3'd0;
            end
        endcase
    end
    // state and datapath registers; gate pins come straight from flops so they never glitch
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            vec   <= 2'd0;
            cnt   <= 16'd0;
            fv    <= 4'd0;
            ec    <= 3'd0;
            ab    <= 2'b00;
        end else begin
            state <= state_n;
            vec   <= vec_n;
            cnt   <= cnt_n;
            fv    <= fv_n;
            ec    <= ec_n;
            ab    <= ab_n;
        end
    end
endmodule
